// File: rtl/div6b3_seq.sv
// div6b3_seq: sequential restoring divider, 6-bit unsigned dividend by 3-bit unsigned divisor.
// One quotient bit per RUN cycle, MSB first; a zero divisor completes on the accepting edge.
module div6b3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       div_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring step per cycle, r_cnt walks 5..0
  // FIN   | results valid, done high; a start here is accepted as in IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [5:0] r_dvd;
  logic [2:0] r_dvs;
  logic [3:0] r_pr;
  logic [2:0] r_cnt;
  logic [5:0] r_qw;
  logic       r_busy;
  logic       r_done;
  logic [5:0] r_quot;
  logic [2:0] r_rem;
  logic       r_dz;

  logic [3:0] w_pr_shift;
  logic       w_ge;
  logic [3:0] w_pr_next;
  logic [5:0] w_q_next;

  // r_pr[3] is always 0 after a step (pr < divisor); folding it into the compare keeps it meaningful
  always_comb begin
    w_pr_shift      = {r_pr[2:0], r_dvd[r_cnt]};
    w_ge            = r_pr[3] | (w_pr_shift >= {1'b0, r_dvs});
    w_pr_next       = w_ge ? (w_pr_shift - {1'b0, r_dvs}) : w_pr_shift;
    w_q_next        = r_qw;
    w_q_next[r_cnt] = w_ge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dvd   <= 6'd0;
      r_dvs   <= 3'd0;
      r_pr    <= 4'd0;
      r_cnt   <= 3'd0;
      r_qw    <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= 6'd0;
      r_rem   <= 3'd0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_pr  <= w_pr_next;
          r_qw  <= w_q_next;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_rem   <= w_pr_next[2:0];
            r_dz    <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_pr  <= 4'd0;
            r_qw  <= 6'd0;
            if (divisor == 3'd0) begin
              r_state <= FIN;
              r_cnt   <= 3'd0;
              r_done  <= 1'b1;
              r_quot  <= 6'h3F;
              r_rem   <= 3'd0;
              r_dz    <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= 3'd5;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_div6b3_seq.sv
// Directed self-checking bench for div6b3_seq; inputs driven and outputs sampled on the falling edge.
module tb_div6b3_seq;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       start    = 1'b0;
  logic [5:0] dividend = 6'd0;
  logic [2:0] divisor  = 3'd0;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_zero;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  div6b3_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns falling edges until done (7 normal, 1 for divisor 0),
  // busy-high samples, and the quotient seen mid-operation.
  task automatic op(input logic [5:0] a, input logic [2:0] b, input bit hold,
                    output int lat, output int busy_cnt, output logic [5:0] q_mid);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    q_mid    = quotient;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) start = 1'b0;
      if (busy) busy_cnt++;
      if (lat == 3) q_mid = quotient;
    end while (!done && lat < 20);
  endtask

  initial begin
    int         lat;
    int         bc;
    int         dones;
    logic [5:0] qm;
    logic [5:0] q_seen;
    logic [2:0] r_seen;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(6'd45, 3'd6, 1'b0, lat, bc, qm);
    check("45/6_lat", lat, 7);
    check("45/6_busy", bc, 6);
    check("45/6_qhold", qm, 0);
    check("45/6_q", quotient, 7);
    check("45/6_r", remainder, 3);
    check("45/6_dz", div_zero, 0);
    check("45/6_busyfin", busy, 0);
    @(negedge clk);
    check("45/6_done1cyc", done, 0);

    op(6'd63, 3'd1, 1'b0, lat, bc, qm);
    check("63/1_qhold", qm, 7);
    check("63/1_q", quotient, 63);
    check("63/1_r", remainder, 0);
    op(6'd5, 3'd7, 1'b0, lat, bc, qm);
    check("5/7_q", quotient, 0);
    check("5/7_r", remainder, 5);
    op(6'd0, 3'd3, 1'b0, lat, bc, qm);
    check("0/3_q", quotient, 0);
    check("0/3_r", remainder, 0);
    check("0/3_lat", lat, 7);
    @(negedge clk);

    op(6'd20, 3'd0, 1'b0, lat, bc, qm);
    check("20/0_lat", lat, 1);
    check("20/0_busy", bc, 0);
    check("20/0_q", quotient, 63);
    check("20/0_r", remainder, 0);
    check("20/0_dz", div_zero, 1);
    @(negedge clk);
    check("20/0_done1cyc", done, 0);
    op(6'd13, 3'd5, 1'b0, lat, bc, qm);
    check("13/5_qhold", qm, 63);
    check("13/5_q", quotient, 2);
    check("13/5_r", remainder, 3);
    check("13/5_dz", div_zero, 0);
    @(negedge clk);

    dividend = 6'd50; divisor = 3'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; dividend = 6'd9; divisor = 3'd2;
    @(negedge clk); start = 1'b0; dividend = 6'd63; divisor = 3'd7;
    dones = 0; q_seen = 6'd0; r_seen = 3'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin dones++; q_seen = quotient; r_seen = remainder; end
    end
    check("rerun_dones", dones, 1);
    check("rerun_q", q_seen, 12);
    check("rerun_r", r_seen, 2);

    dividend = 6'd50; divisor = 3'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);
    op(6'd7, 3'd3, 1'b0, lat, bc, qm);
    check("7/3_lat", lat, 7);
    check("7/3_q", quotient, 2);
    check("7/3_r", remainder, 1);
    @(negedge clk);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        op(6'(a), 3'(b), 1'b1, lat, bc, qm);
        check("exh_lat", lat, (b == 0) ? 1 : 7);
        check("exh_q", quotient, (b == 0) ? 63 : a / b);
        check("exh_r", remainder, (b == 0) ? 0 : a % b);
        check("exh_dz", div_zero, (b == 0) ? 1 : 0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("exh_end_done", done, 0);
    check("exh_end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
